// File: rtl/pcs_gearbox_tx_pkg.sv
// Shared PCS definitions for the 64b/66b TX gearbox: period constants, sync encodings, block type.
package pcs_gearbox_tx_pkg;

  localparam int unsigned GB_SEQ_W = 7;
  localparam logic [GB_SEQ_W-1:0] GB_PERIOD = 7'd66;
  localparam logic [GB_SEQ_W-1:0] GB_STALL_START = 7'd64;
  localparam int unsigned GB_BUF_W = 96;

  // Sync header encodings as transmitted, LSB first
  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  typedef struct packed {
    logic [63:0] payload;
    logic [1:0]  sync;
  } pcs_block_t;

  // Append offset equals the residue left in the buffer: 2 * ceil(seq / 2)
  function automatic logic [GB_SEQ_W-1:0] gb_append_off(input logic [GB_SEQ_W-1:0] seq);
    return {seq[GB_SEQ_W-1:1], 1'b0} + {{(GB_SEQ_W-2){1'b0}}, seq[0], 1'b0};
  endfunction

endpackage

// File: rtl/pcs_gearbox_seq.sv
// Gearbox period sequencer: counts 0..65, stalls upstream on the last two positions and
// tells the datapath where to append the current beat.
module pcs_gearbox_seq
  import pcs_gearbox_tx_pkg::*;
(
  input  logic                clk,
  input  logic                nreset,
  input  logic                valid_i,
  output logic                ready_o,
  output logic                advance_o,
  output logic                hdr_beat_o,
  output logic [GB_SEQ_W-1:0] shift_off_o
);

  logic [GB_SEQ_W-1:0] seq_q, seq_d;

  assign ready_o     = (seq_q < GB_STALL_START);
  // Stall cycles always advance; otherwise only an accepted beat does
  assign advance_o   = ~ready_o | valid_i;
  assign hdr_beat_o  = ready_o & ~seq_q[0];
  assign shift_off_o = gb_append_off(seq_q);

  always_comb begin
    seq_d = seq_q;
    if (advance_o) begin
      seq_d = (seq_q == GB_PERIOD - 7'd1) ? '0 : seq_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

endmodule

// File: rtl/pcs_gearbox_tx.sv
// 66b->32b TX gearbox: packs header+two-beat blocks into a continuous 32-bit SERDES stream.
// Define GEARBOX_ERR_EN to add the sticky underflow flag err_o.
module pcs_gearbox_tx
  import pcs_gearbox_tx_pkg::*;
#(
  parameter int unsigned LEN    = 32,
  parameter int unsigned HEAD_W = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [LEN-1:0]    data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [LEN-1:0]    data_o
`ifdef GEARBOX_ERR_EN
  ,
  output logic              err_o
`endif
);

  logic                advance;
  logic                hdr_beat;
  logic [GB_SEQ_W-1:0] shift_off;

  logic [GB_BUF_W-1:0] buf_q, buf_d;
  logic [GB_BUF_W-1:0] app_vec, buf_app;
  logic [LEN-1:0]      data_q, data_d;
  logic                valid_q, valid_d;

  pcs_gearbox_seq u_seq (
    .clk        (clk),
    .nreset     (nreset),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .advance_o  (advance),
    .hdr_beat_o (hdr_beat),
    .shift_off_o(shift_off)
  );

  always_comb begin
    app_vec = '0;
    if (hdr_beat) begin
      app_vec[LEN+HEAD_W-1:0] = {data_i, head_i};
    end else begin
      app_vec[LEN-1:0] = data_i;
    end
    // Bits above the fill are always zero, so OR-ing places the beat on top of the residue
    buf_app = ready_o ? (buf_q | (app_vec << shift_off)) : buf_q;

    buf_d   = buf_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (advance) begin
      buf_d   = buf_app >> LEN;
      data_d  = buf_app[LEN-1:0];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

`ifdef GEARBOX_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (ready_o & ~valid_i);
    end
  end

  assign err_o = err_q;
`endif

endmodule
